// File: rtl/audio_out_sample_fifo.sv
// Stereo 24-bit sample FIFO between the CPU/DMA writer and the I2S serializer, popped on LOAD.
// Optional build macro AUDIO_FIFO_UNDERRUN_MUTE_EN: outputs mute on underrun instead of repeating the last pair.
module audio_out_sample_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int LOW_MARK   = 4
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  LOAD,
    input  logic                  WR_EN,
    input  logic [23:0]           WR_LEFT,
    input  logic [23:0]           WR_RIGHT,
    input  logic                  STATUS_CLR,
    output logic [23:0]           OUT_LEFT,
    output logic [23:0]           OUT_RIGHT,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  LOW_WATER,
    output logic                  OVERFLOW,
    output logic                  UNDERRUN,
    output logic [15:0]           UNDERRUN_CNT
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LEVEL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    typedef struct packed {
        logic [23:0] left;
        logic [23:0] right;
    } pair_t;

    pair_t                 mem [DEPTH];
    pair_t                 rd_data;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level_next;
    logic                  pop_ok;
    logic                  underrun_ev;
    logic                  push_ok;
    logic                  overflow_ev;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        pop_ok      = 1'b0;
        underrun_ev = 1'b0;
        push_ok     = 1'b0;
        overflow_ev = 1'b0;
        level_next  = LEVEL;
        rd_data     = mem[rd_ptr];

        if (LOAD) begin
            pop_ok      = (LEVEL != '0);
            underrun_ev = (LEVEL == '0);
        end

        // A full FIFO still accepts a push when the same cycle frees a slot.
        if (WR_EN) begin
            push_ok     = (LEVEL != LEVEL_MAX) || pop_ok;
            overflow_ev = !push_ok;
        end

        if (push_ok && !pop_ok) begin
            level_next = LEVEL + LEVEL_ONE;
        end else if (!push_ok && pop_ok) begin
            level_next = LEVEL - LEVEL_ONE;
        end
    end

    // NOTE: the sample RAM has no reset; its contents are meaningless until written,
    // and leaving it unreset lets it map onto distributed RAM.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{left: WR_LEFT, right: WR_RIGHT};
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            LEVEL     <= '0;
            FULL      <= 1'b0;
            EMPTY     <= 1'b1;
            LOW_WATER <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            LEVEL     <= level_next;
            FULL      <= (level_next == LEVEL_MAX);
            EMPTY     <= (level_next == '0);
            LOW_WATER <= (int'(level_next) <= LOW_MARK);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            OUT_LEFT  <= '0;
            OUT_RIGHT <= '0;
        end else if (pop_ok) begin
            OUT_LEFT  <= rd_data.left;
            OUT_RIGHT <= rd_data.right;
        end else if (underrun_ev) begin
`ifdef AUDIO_FIFO_UNDERRUN_MUTE_EN
            OUT_LEFT  <= '0;
            OUT_RIGHT <= '0;
`else
            OUT_LEFT  <= OUT_LEFT;
            OUT_RIGHT <= OUT_RIGHT;
`endif
        end
    end

    // A new event in the same cycle as STATUS_CLR wins over the clear.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            OVERFLOW     <= 1'b0;
            UNDERRUN     <= 1'b0;
            UNDERRUN_CNT <= '0;
        end else begin
            OVERFLOW <= overflow_ev || (OVERFLOW && !STATUS_CLR);
            UNDERRUN <= underrun_ev || (UNDERRUN && !STATUS_CLR);
            if (underrun_ev) begin
                if (STATUS_CLR) begin
                    UNDERRUN_CNT <= 16'd1;
                end else if (UNDERRUN_CNT != 16'hFFFF) begin
                    UNDERRUN_CNT <= UNDERRUN_CNT + 16'd1;
                end
            end else if (STATUS_CLR) begin
                UNDERRUN_CNT <= '0;
            end
        end
    end

endmodule

// File: doc/audio_out_sample_fifo.md
# audio_out_sample_fifo

Stereo sample FIFO feeding the 24-bit left/right output-channel inputs of the audio I/O block.
- Write side: the CPU/DMA pushes 24-bit stereo sample pairs.
- Read side: one pair is popped on every frame-boundary `LOAD` strobe from the audio clock generator and held stable on `OUT_LEFT`/`OUT_RIGHT` for the I2S serializer.
- Reports fill level, low-water and sticky overflow/underrun status, so software can refill on interrupt instead of writing per sample.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: FIFO depth = 2^`DEPTH_LOG2` stereo entries (legal range 2..10).
- `LOW_MARK`, 4: `LOW_WATER` asserts while level <= `LOW_MARK`.

Ports:
- `CLK`  in  1: audio system clock, 147.5 MHz; everything is clocked on its rising edge.
- `RESETN`  in  1: reset, synchronous, active-low.
- `LOAD`  in  1: one-`CLK` frame strobe from the audio clock generator; causes a pop.
- `WR_EN`  in  1: push request, one entry per cycle while high.
- `WR_LEFT`  in  24: left sample to push.
- `WR_RIGHT`  in  24: right sample to push.
- `STATUS_CLR`  in  1: clears `OVERFLOW`, `UNDERRUN` and `UNDERRUN_CNT`.
- `OUT_LEFT`  out  24: left sample currently presented to the serializer.
- `OUT_RIGHT`  out  24: right sample currently presented.
- `LEVEL`  out  `DEPTH_LOG2`+1: number of stored entries, 0..2^`DEPTH_LOG2`.
- `FULL`  out  1: `LEVEL` == 2^`DEPTH_LOG2`.
- `EMPTY`  out  1: `LEVEL` == 0.
- `LOW_WATER`  out  1: `LEVEL` <= `LOW_MARK`.
- `OVERFLOW`  out  1: sticky; set when a push was dropped.
- `UNDERRUN`  out  1: sticky; set when `LOAD` found the FIFO empty.
- `UNDERRUN_CNT`  out  16: saturating count of underrun frames.

## Operation
Storage:
- Circular buffer of 48-bit entries, `{left, right}`, inferred as distributed RAM.
- Write pointer and read pointer are each `DEPTH_LOG2` bits and wrap modulo depth.
- A separate `LEVEL` register is the only source of `FULL` and `EMPTY`.

Pop, on a cycle with `LOAD`=1:
- If `LEVEL` > 0: the entry at the read pointer goes into the `OUT_LEFT`/`OUT_RIGHT` registers, the read pointer advances and `LEVEL` decrements.
- If `LEVEL` == 0: an underrun occurs. `UNDERRUN` is set, `UNDERRUN_CNT` increments and saturates at 0xFFFF, and the outputs behave as described under Configuration. Pointers are unchanged.

Push, on a cycle with `WR_EN`=1:
- Accepted if `LEVEL` < depth, or if `LEVEL` == depth and a successful pop happens in the same cycle.
- On accept: data is written at the write pointer, the write pointer advances and `LEVEL` increments (net `LEVEL` change is 0 with a simultaneous pop).
- Otherwise the push is dropped, `OVERFLOW` is set and the FIFO is unchanged.

Simultaneous events:
- Push and pop while `LEVEL` == 0: the pop is an underrun. The push is stored, and `LEVEL` becomes 1 on the next cycle. There is no bypass of the FIFO.
- `STATUS_CLR` together with a new overflow or underrun event: the set wins and the counter becomes 1.

## Timing
- Reset (`RESETN`=0 at an edge): `OUT_LEFT`=`OUT_RIGHT`=0, `LEVEL`=0, `EMPTY`=1, `FULL`=0, `LOW_WATER`=1, `OVERFLOW`=0, `UNDERRUN`=0, `UNDERRUN_CNT`=0, and both pointers = 0. Reset in the middle of operation discards all contents. RAM contents are don't-care.
- All outputs are registered. `OUT_*` change exactly one `CLK` after the `LOAD` cycle.
- The serializer captures on the same `LOAD` edge, so it receives the previously popped pair. The sample popped at frame N is transmitted in frame N+1: a fixed one-frame latency.
- `LEVEL`, the flags and the counter update one `CLK` after the causing `WR_EN`/`LOAD`/`STATUS_CLR` cycle.
- No write-side handshake: the writer must check `FULL`/`LEVEL` beforehand. Back-to-back pushes at one per `CLK` are supported.
- `LOAD` strobes are at least 3072 `CLK` apart. `LOAD` held high for two consecutive cycles is treated as two pops.

## Configuration
Macro `AUDIO_FIFO_UNDERRUN_MUTE_EN`:
- Defined: on underrun, `OUT_LEFT`/`OUT_RIGHT` load 0 (mute).
- Undefined: on underrun, `OUT_LEFT`/`OUT_RIGHT` keep the last successfully popped pair (sample repeat).
- Status flag and counter behaviour is identical in both builds.

## Test plan
- Reset then 3 `LOAD` strobes with no writes: `UNDERRUN`=1, `UNDERRUN_CNT`=3, `OUT_*`=0 in both builds, `LEVEL`=0.
- Push 0x000001/0x800001 and 0x000002/0x800002, then `LOAD`: one cycle later `OUT_LEFT`=0x000001 and `OUT_RIGHT`=0x800001, `LEVEL`=1. A second `LOAD` presents 0x000002/0x800002.
- Push 17 entries into depth 16: `FULL`=1, `LEVEL`=16, `OVERFLOW`=1. The 17th value never appears on `OUT_*` across 16 `LOAD`s, and the 16 values appear in order, so the pointers wrap correctly.
- At `LEVEL`=16, `WR_EN` and `LOAD` in the same cycle: the push is accepted, `LEVEL` stays 16 and `OVERFLOW` stays 0.
- Push A, one `LOAD`, then two `LOAD`s with the FIFO empty: without the macro `OUT_*` = A after each underrun; with `AUDIO_FIFO_UNDERRUN_MUTE_EN` defined `OUT_*` = 0. `UNDERRUN_CNT`=2, and `STATUS_CLR` returns it to 0.
- Fill to 10 entries, assert `RESETN`=0 for one cycle: `LEVEL`=0, `EMPTY`=1, all outputs at reset values. The next push/`LOAD` pair returns the new data.
